// File: rtl/bus_arb_pkg.sv
// Shared definitions for the bus drive arbiter: FSM state type and default sizing.
package bus_arb_pkg;

    // IDLE: bus free; GRANT: one driver enabled; TURN: one all-off cycle between owners
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } arb_state_t;

    localparam int DEF_N_MASTERS = 4;
    localparam int DEF_MAX_HOLD  = 16;

endpackage : bus_arb_pkg

// File: rtl/bus_drive_arbiter_rr_pick.sv
// Combinational circular priority picker: returns the first set req bit at or
// after ptr, wrapping modulo N_MASTERS. valid is low when no bit is set.
module rr_pick
    import bus_arb_pkg::*;
#(
    parameter  int N_MASTERS = DEF_N_MASTERS,
    localparam int IDX_W     = $clog2(N_MASTERS)
) (
    input  logic [N_MASTERS-1:0] req,
    input  logic [IDX_W-1:0]     ptr,
    output logic [IDX_W-1:0]     winner,
    output logic                 valid
);

    // Scan candidates in priority order starting from ptr; the first hit wins
    always_comb begin : p_pick
        logic [IDX_W-1:0] cand;
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        winner = '0;
        valid  = 1'b0;
        cand   = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            cand = IDX_W'((int'(ptr) + i) % N_MASTERS);
            if (!valid && req[cand]) begin
                valid  = 1'b1;
                winner = cand;
            end
        end
    end

endmodule : rr_pick

// File: rtl/bus_drive_arbiter.sv
// Round-robin arbiter driving the enable pins of tristate buffers on a shared bus.
// Grants are registered and one-hot; every ownership change (including the same
// master returning) passes through a single all-off TURN cycle.
// Optional feature macro: ARB_TIMEOUT_EN -- when defined, an owner that has held
// the bus for MAX_HOLD cycles is forced off if any other master is requesting.
module bus_drive_arbiter
    import bus_arb_pkg::*;
#(
    parameter  int N_MASTERS = DEF_N_MASTERS,
    parameter  int MAX_HOLD  = DEF_MAX_HOLD,
    localparam int IDX_W     = $clog2(N_MASTERS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_MASTERS-1:0] req,
    output logic [N_MASTERS-1:0] grant,
    output logic [IDX_W-1:0]     owner,
    output logic                 bus_busy
);

    localparam logic [N_MASTERS-1:0] ONE_HOT_LSB = N_MASTERS'(1);
    localparam logic [IDX_W-1:0]     LAST_IDX    = IDX_W'(N_MASTERS - 1);

    // Reject sizes the picker and counter are not meant for at elaboration time
    if (N_MASTERS < 2 || N_MASTERS > 8 || MAX_HOLD < 1) begin : g_param_check
        $error("bus_drive_arbiter: N_MASTERS must be 2..8 and MAX_HOLD >= 1");
    end

    arb_state_t       state;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_valid;
    logic [IDX_W-1:0] next_ptr;
    logic             hold_expired;
    logic             release_bus;

    rr_pick #(
        .N_MASTERS (N_MASTERS)
    ) u_pick (
        .req    (req),
        .ptr    (rr_ptr),
        .winner (pick_idx),
        .valid  (pick_valid)
    );

`ifdef ARB_TIMEOUT_EN
    localparam int                HOLD_W   = $clog2(MAX_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);

    logic [HOLD_W-1:0] hold_cnt;

    // A saturated owner only yields when someone else is actually waiting
    assign hold_expired = (hold_cnt == HOLD_MAX) && ((req & ~grant) != '0);

    // Count consecutive GRANT cycles of the current owner, saturating at MAX_HOLD
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_cnt <= '0;
        end else if (state != GRANT && pick_valid) begin
            hold_cnt <= HOLD_W'(1);
        end else if (state == GRANT && !release_bus && hold_cnt != HOLD_MAX) begin
            hold_cnt <= hold_cnt + 1'b1;
        end
    end
`else
    // Without the timeout the owner keeps the bus for as long as it requests
    assign hold_expired = 1'b0;
`endif

    // Release on dropped request (or forced timeout); a release always wins
    // over new requests arriving on the same edge, which are served from TURN.
    assign release_bus = (state == GRANT) && (!req[owner] || hold_expired);
    assign next_ptr    = (owner == LAST_IDX) ? '0 : owner + 1'b1;

    // Arbitration FSM with registered grant, owner, busy flag and rotation pointer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            grant    <= '0;
            owner    <= '0;
            bus_busy <= 1'b0;
            rr_ptr   <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every register sees pre-edge values.
            case (state)
                IDLE, TURN: begin
                    if (pick_valid) begin
                        state    <= GRANT;
                        grant    <= ONE_HOT_LSB << pick_idx;
                        owner    <= pick_idx;
                        bus_busy <= 1'b1;
                    end else begin
                        state    <= IDLE;
                        grant    <= '0;
                        bus_busy <= 1'b0;
                    end
                end
                GRANT: begin
                    if (release_bus) begin
                        state  <= TURN;
                        grant  <= '0;
                        rr_ptr <= next_ptr;
                    end
                end
                default: begin
                    state    <= IDLE;
                    grant    <= '0;
                    bus_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule : bus_drive_arbiter

// File: tb/tb_bus_drive_arbiter.sv
// Self-checking bench for bus_drive_arbiter (N_MASTERS=4, MAX_HOLD=16).
// Directed scenarios pin literal grant sequences; a random phase is compared
// every cycle against a behavioural model of the arbitration rules.
// Honours ARB_TIMEOUT_EN the same way the design does.
module tb_bus_drive_arbiter;

    localparam int N        = 4;
    localparam int MAX_HOLD = 16;
`ifdef ARB_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] req = '0;
    logic [N-1:0] grant;
    logic [1:0]   owner;
    logic         bus_busy;

    int n_checks = 0;
    int n_fail   = 0;

    bus_drive_arbiter #(
        .N_MASTERS (N),
        .MAX_HOLD  (MAX_HOLD)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .grant    (grant),
        .owner    (owner),
        .bus_busy (bus_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #2;
        rst = 1'b0;
        tick();
    endtask

    // ---------------- behavioural model ----------------
    logic [N-1:0] m_grant = '0;
    int           m_owner = 0;
    bit           m_busy  = 1'b0;
    int           m_ptr   = 0;
    int           m_hold  = 0;

    function automatic int first_req(input logic [N-1:0] r, input int p);
        for (int i = 0; i < N; i++) begin
            int j;
            j = (p + i) % N;
            if (((r >> j) & 1) != 0) return j;
        end
        return -1;
    endfunction

    // Model: an owner keeps the bus while requesting; any release costs one idle
    // cycle; the next owner is the first requester at or after owner+1.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_grant = '0;
            m_owner = 0;
            m_busy  = 1'b0;
            m_ptr   = 0;
            m_hold  = 0;
        end else if (m_grant != '0) begin : m_owned
            bit           rel;
            logic [N-1:0] others;
            others = req & ~m_grant;
            rel    = (((req >> m_owner) & 1) == 0);
            if (TIMEOUT_EN && m_hold >= MAX_HOLD && others != '0) rel = 1'b1;
            if (rel) begin
                m_grant = '0;
                m_ptr   = (m_owner + 1) % N;
            end else if (m_hold < MAX_HOLD) begin
                m_hold++;
            end
        end else begin : m_free
            int w;
            w = first_req(req, m_ptr);
            if (w >= 0) begin
                m_grant = N'(1) << w;
                m_owner = w;
                m_hold  = 1;
                m_busy  = 1'b1;
            end else begin
                m_busy = 1'b0;
            end
        end
    end

    // Per-cycle compare against the model plus contention invariants
    logic [N-1:0] prev_grant = '0;
    always @(negedge clk) begin
        check("grant", 32'(grant), 32'(m_grant));
        check("owner", 32'(owner), 32'(m_owner));
        check("bus_busy", 32'(bus_busy), 32'(m_busy));
        check("onehot0", 32'($onehot0(grant)), 32'd1);
        check("turnaround", 32'(grant != '0 && prev_grant != '0 && grant != prev_grant), 32'd0);
        prev_grant = grant;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t limit 1000000", $time);
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed scenarios then random traffic ----------------
    initial begin
        logic [N-1:0] exp;
        int           den;

        repeat (2) tick();
        check("reset_grant", 32'(grant), 32'h0);
        check("reset_busy", 32'(bus_busy), 32'h0);
        rst = 1'b0;

        // Async reset in the middle of a GRANT cycle
        req = 4'b0010;
        tick();
        check("pre_rst_grant", 32'(grant), 32'b0010);
        check("pre_rst_owner", 32'(owner), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_grant", 32'(grant), 32'h0);
        check("async_rst_busy", 32'(bus_busy), 32'h0);
        check("async_rst_owner", 32'(owner), 32'h0);
        tick();
        rst = 1'b0;
        tick();
        check("post_rst_grant", 32'(grant), 32'b0010);
        req = '0;
        tick();
        tick();

        // Simultaneous request from IDLE with rr_ptr=0
        do_reset();
        req = 4'b1010;
        tick();
        check("simul_first", 32'(grant), 32'b0010);
        req = 4'b1000;
        tick();
        check("simul_gap", 32'(grant), 32'b0000);
        check("simul_gap_busy", 32'(bus_busy), 32'd1);
        tick();
        check("simul_second", 32'(grant), 32'b1000);
        req = '0;
        tick();
        tick();
        check("idle_busy", 32'(bus_busy), 32'd0);
        check("idle_owner", 32'(owner), 32'd3);

        // Rotation and wrap with everyone requesting
        do_reset();
        req = 4'b1111;
        tick();
        for (int k = 0; k < 5; k++) begin
            exp = 4'b0001 << (k % 4);
            check("rot_grant_c1", 32'(grant), 32'(exp));
            tick();
            check("rot_grant_c2", 32'(grant), 32'(exp));
            tick();
            check("rot_grant_c3", 32'(grant), 32'(exp));
            req = 4'b1111 & ~exp;
            tick();
            check("rot_gap", 32'(grant), 32'h0);
            req = 4'b1111;
            tick();
        end
        req = '0;
        tick();
        tick();

        // Same master releasing and re-requesting still pays the gap
        do_reset();
        req = 4'b0100;
        tick();
        check("rereq_first", 32'(grant), 32'b0100);
        req = '0;
        tick();
        check("rereq_gap", 32'(grant), 32'h0);
        req = 4'b0100;
        tick();
        check("rereq_again", 32'(grant), 32'b0100);
        req = '0;
        tick();
        tick();

        // Long hold by master 0 while master 3 waits
        do_reset();
        req = 4'b0001;
        tick();
        check("hold_c1", 32'(grant), 32'b0001);
        req = 4'b1001;
        if (TIMEOUT_EN) begin
            for (int i = 2; i <= MAX_HOLD; i++) begin
                tick();
                check("hold_timeout_window", 32'(grant), 32'b0001);
            end
            tick();
            check("hold_timeout_gap", 32'(grant), 32'h0);
            tick();
            check("hold_timeout_next", 32'(grant), 32'b1000);
        end else begin
            for (int i = 0; i < 110; i++) begin
                tick();
                check("hold_forever", 32'(grant), 32'b0001);
            end
        end
        req = '0;
        tick();
        tick();

        // Random traffic: bursty first, then long holds to reach saturation
        do_reset();
        for (int c = 0; c < 10000; c++) begin
            den = (c < 5000) ? 8 : 40;
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(den - 1) == 0) req[b] = ~req[b];
            end
            tick();
        end
        req = '0;
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_bus_drive_arbiter
